// File: rtl/logo_writer.sv
//==============================================================================
// Module   : logo_writer
// Purpose  : Unpacks a stream of 1-bit-per-pixel logo bytes (MSB = leftmost
//            pixel) into single-pixel writes into a 128x128 image memory.
//            Each accepted byte yields eight consecutive write cycles.
// Option   : define LOGO_WRITER_CHECKSUM_EN to add an 8-bit XOR checksum of
//            every accepted byte on output port 'checksum'.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module logo_writer #(
    parameter int WIDTH_LOGO  = 80,
    parameter int HEIGHT_LOGO = 96
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       wr_en,
    output logic [6:0] wr_x,
    output logic [6:0] wr_y,
    output logic       wr_pixel,
    output logic       busy,
    output logic       done
`ifdef LOGO_WRITER_CHECKSUM_EN
    ,
    output logic [7:0] checksum
`endif
);

    localparam logic [6:0] X_LAST = 7'(WIDTH_LOGO - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT_LOGO - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BYTE = 2'd1,
        S_SHIFT     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
`ifdef LOGO_WRITER_CHECKSUM_EN
    logic [7:0] cks_q, cks_d;
`endif

    // State and datapath registers, cleared asynchronously by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            x_q     <= 7'd0;
            y_q     <= 7'd0;
            shift_q <= 8'd0;
            cnt_q   <= 3'd0;
`ifdef LOGO_WRITER_CHECKSUM_EN
            cks_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef LOGO_WRITER_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    // Next-state logic: byte capture, bit shifting and raster coordinate walk
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef LOGO_WRITER_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_BYTE;
                    x_d     = 7'd0;
                    y_d     = 7'd0;
`ifdef LOGO_WRITER_CHECKSUM_EN
                    cks_d   = 8'd0;
`endif
                end
            end
            S_WAIT_BYTE: begin
                // abort wins over a byte offered in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                end else if (byte_valid) begin
                    shift_d = byte_in;
                    cnt_d   = 3'd0;
                    state_d = S_SHIFT;
`ifdef LOGO_WRITER_CHECKSUM_EN
                    cks_d   = cks_q ^ byte_in;
`endif
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    shift_d = {shift_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                        // Final pixel: leftover bits of this byte are dropped and
                        // the coordinates stay on the last written pixel.
                        state_d = S_DONE;
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = 7'd0;
                            y_d = y_q + 7'd1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                        if (cnt_q == 3'd7) begin
                            state_d = S_WAIT_BYTE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, no input-to-output paths
    assign byte_ready = (state_q == S_WAIT_BYTE);
    assign wr_en      = (state_q == S_SHIFT);
    assign wr_pixel   = shift_q[7];
    assign wr_x       = x_q;
    assign wr_y       = y_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
`ifdef LOGO_WRITER_CHECKSUM_EN
    assign checksum   = cks_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logo_writer.sv
//==============================================================================
// Module   : tb_logo_writer
// Purpose  : Directed self-checking bench for logo_writer (80x96 default).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_logo_writer;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       abort;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       wr_en;
    logic [6:0] wr_x;
    logic [6:0] wr_y;
    logic       wr_pixel;
    logic       busy;
    logic       done;
`ifdef LOGO_WRITER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logo_writer #(
        .WIDTH_LOGO  (80),
        .HEIGHT_LOGO (96)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_pixel   (wr_pixel),
        .busy       (busy),
        .done       (done)
`ifdef LOGO_WRITER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int mode, input int k);
        if (mode == 1) return 8'hFF;
        return 8'((k * 37 + 5) & 255);
    endfunction

    // Complete 80x96 load; rnd=1 gates byte_valid randomly
    task automatic run_load(input int mode, input bit rnd, input string tag);
        int         wc = 0, acc = 0, bad = 0, overlap = 0, dones = 0, cyc = 0;
        logic [7:0] xsum = 8'd0;
        logic [7:0] cur;
        logic [6:0] lx = 7'd0, ly = 7'd0;
        bit         last_prev = 1'b0, done_ok = 1'b0, fin = 1'b0, accept;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!fin && cyc < 20000) begin
            if (wr_en) begin
                cur = pat(mode, wc / 8);
                if (wr_x !== 7'(wc % 80) || wr_y !== 7'(wc / 80) ||
                    wr_pixel !== cur[7 - (wc % 8)]) bad++;
                if (byte_ready) overlap++;
                wc++;
                lx = wr_x;
                ly = wr_y;
            end
            if (done) begin
                dones++;
                done_ok = last_prev && (wc == 7680);
                fin = 1'b1;
                if (byte_ready) overlap++;
            end
            last_prev  = wr_en && (wc == 7680);
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in    = pat(mode, acc);
            accept     = byte_ready && byte_valid;
            tick();
            cyc++;
            if (accept) begin
                xsum ^= pat(mode, acc);
                acc++;
            end
        end
        byte_valid = 1'b0;
        chk({tag, "_writes"},   wc, 7680);
        chk({tag, "_bytes"},    acc, 960);
        chk({tag, "_seq_bad"},  bad, 0);
        chk({tag, "_ready_overlap"}, overlap, 0);
        chk({tag, "_last_x"},   lx, 79);
        chk({tag, "_last_y"},   ly, 95);
        chk({tag, "_done_cnt"}, dones, 1);
        chk({tag, "_done_timing"}, done_ok, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_after"}, done, 0);
`ifdef LOGO_WRITER_CHECKSUM_EN
        chk({tag, "_checksum"}, checksum, xsum);
`endif
    endtask

    initial begin : stim
        logic [7:0] a5;
        int         wc, bad;
        bit         hit;
        a5 = 8'hA5;

        clr = 1'b1; start = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_xy", {wr_x, wr_y}, 0);
        chk("rst_pixel", wr_pixel, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Single byte A5: eight writes x=0..7 with MSB-first pixels
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", byte_ready, 1);
        chk("start_wr_en", wr_en, 0);
        byte_in = 8'hA5; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("a5_wr_en", wr_en, 1);
            chk("a5_pixel", wr_pixel, a5[7 - i]);
            chk("a5_x", wr_x, i);
            chk("a5_y", wr_y, 0);
            chk("a5_ready", byte_ready, 0);
            tick();
        end
        chk("a5_after_wr_en", wr_en, 0);
        chk("a5_after_ready", byte_ready, 1);
`ifdef LOGO_WRITER_CHECKSUM_EN
        chk("a5_checksum", checksum, 8'hA5);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_wait_busy", busy, 0);
        chk("abort_wait_done", done, 0);

        // Full loads: constant-valid, then randomly stalled
        run_load(0, 1'b0, "full");
        run_load(0, 1'b1, "rnd");

        // Abort on the 3rd write of byte 5; a start while busy must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        wc = 0; bad = 0; hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            start = 1'b0;
            if (wr_en) begin
                if (wr_x !== 7'(wc % 80) || wr_y !== 7'(wc / 80)) bad++;
                if (wc == 34) begin
                    abort = 1'b1;
                    hit = 1'b1;
                end
                if (wc == 10) start = 1'b1;
                wc++;
            end
            byte_valid = 1'b1;
            byte_in = 8'h5A;
            tick();
        end
        abort = 1'b0; start = 1'b0; byte_valid = 1'b0;
        chk("abort_reached", hit, 1);
        chk("abort_seq_bad", bad, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", byte_ready, 0);
        tick();
        chk("abort_done_later", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        byte_in = 8'h80; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        chk("restart_wr_en", wr_en, 1);
        chk("restart_xy", {wr_x, wr_y}, 0);
        chk("restart_pixel", wr_pixel, 1);

        // clr mid-SHIFT: outputs clear without a clock edge
        tick();
        tick();
        chk("pre_clr_wr_en", wr_en, 1);
        clr = 1'b1;
        #2;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_wr_en", wr_en, 0);
        chk("clr_ready", byte_ready, 0);
        chk("clr_xy", {wr_x, wr_y}, 0);
        chk("clr_pixel", wr_pixel, 0);
`ifdef LOGO_WRITER_CHECKSUM_EN
        chk("clr_checksum", checksum, 0);
`endif
        tick();
        clr = 1'b0;
        tick();
        chk("post_clr_done", done, 0);
        chk("post_clr_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        byte_in = 8'hFF; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        chk("clr_restart_xy", {wr_x, wr_y}, 0);
        chk("clr_restart_wr_en", wr_en, 1);
        for (int i = 0; i < 8; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;

`ifdef LOGO_WRITER_CHECKSUM_EN
        // XOR accumulation of 01,02,04 and of 960 x FF
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cks_cleared", checksum, 0);
        for (int b = 0; b < 3; b++) begin
            byte_in = 8'(1 << b); byte_valid = 1'b1;
            tick();
            byte_valid = 1'b0;
            for (int i = 0; i < 8; i++) tick();
        end
        chk("cks_07", checksum, 8'h07);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_load(1, 1'b0, "ff");
        chk("cks_ff_zero", checksum, 8'h00);
        tick();
        tick();
        chk("cks_ff_hold", checksum, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logo_writer.md
LOGO_WRITER -- requirements
Module: logo_writer

Interface
REQ-001 Parameter WIDTH_LOGO, default 80, logo width in pixels (1..128).
REQ-002 Parameter HEIGHT_LOGO, default 96, logo height in pixels (1..128).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 clr  input  1  asynchronous reset, active-high.
REQ-005 start  input  1  single-cycle request to begin a logo load.
REQ-006 abort  input  1  cancel an in-progress load.
REQ-007 byte_in  input  8  packed pixel byte, MSB = leftmost pixel.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  writer accepts byte_in this cycle.
REQ-010 wr_en  output  1  image-memory write strobe.
REQ-011 wr_x  output  7  image column of current write (x_img space, 128x128).
REQ-012 wr_y  output  7  image row of current write (y_img space).
REQ-013 wr_pixel  output  1  pixel value written (1 = logo pixel, 0 = background).
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  one-cycle pulse on successful load completion.

Function
REQ-016 The block SHALL implement states IDLE, WAIT_BYTE, SHIFT, DONE, with all outputs derived from registers only.
REQ-017 In IDLE, start=1 SHALL move to WAIT_BYTE and load pixel coordinates x=0, y=0; busy SHALL be 1 in every state except IDLE.
REQ-018 byte_ready SHALL be 1 only in WAIT_BYTE; a byte is accepted on an edge where byte_valid=1 and byte_ready=1, captured into an 8-bit shift register, bit count cleared, state to SHIFT.
REQ-019 In SHIFT, wr_en SHALL be 1 every cycle; wr_pixel = shift register bit 7, wr_x/wr_y = current coordinates; shift register SHALL shift left by one each cycle.
REQ-020 Byte accepted at edge N SHALL produce wr_en high on cycles N+1 through N+8 (8 writes), then return to WAIT_BYTE; sustained throughput is one byte per 9 cycles.
REQ-021 Coordinate advance after each write: x+1; when x = WIDTH_LOGO-1, x wraps to 0 and y+1.
REQ-022 When the write at (WIDTH_LOGO-1, HEIGHT_LOGO-1) completes, the state SHALL go to DONE even mid-byte; remaining bits of that byte are discarded.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge with wr_en=0 and no done pulse; abort has priority over byte acceptance and SHIFT progress.
REQ-026 wr_en SHALL never be 1 for coordinates with x >= WIDTH_LOGO or y >= HEIGHT_LOGO.
REQ-027 Default 80x96 load SHALL consume exactly 960 bytes and issue exactly 7680 writes.

Reset
REQ-028 clr=1 SHALL asynchronously force IDLE, busy=0, done=0, wr_en=0, byte_ready=0, wr_x=0, wr_y=0, wr_pixel=0, shift register=0.
REQ-029 clr asserted mid-load SHALL abandon the load without a done pulse; a new start after clr release SHALL begin at (0,0).

Configuration
REQ-030 With macro LOGO_WRITER_CHECKSUM_EN defined, the block SHALL add output checksum[7:0], cleared to 0 on clr and on start acceptance, XOR-accumulated with each accepted byte, held stable after done until the next start.
REQ-031 Without LOGO_WRITER_CHECKSUM_EN, the checksum port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 clr pulse mid-SHIFT -> all outputs at reset values immediately, state IDLE, no done.
REQ-033 start, byte 8'hA5 valid at edge N -> wr_en cycles N+1..N+8, wr_pixel 1,0,1,0,0,1,0,1, wr_x 0..7, wr_y 0.
REQ-034 Full 80x96 load of 960 bytes with byte_valid always 1 -> 7680 writes, row wrap at x=79 to (0,y+1), last write (79,95), done pulse one cycle later, busy falls after done.
REQ-035 byte_valid toggled randomly -> no writes while WAIT_BYTE stalled, byte_ready never 1 outside WAIT_BYTE, write sequence identical to REQ-034.
REQ-036 abort on 3rd write of byte 5 -> wr_en 0 next cycle, IDLE, no done; subsequent start restarts at (0,0); start during busy ignored.
REQ-037 With LOGO_WRITER_CHECKSUM_EN, bytes 8'h01, 8'h02, 8'h04 -> checksum 8'h07; all 960 bytes 8'hFF -> checksum 8'h00.
